// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Produces {hi_o, lo_o} = {remainder, quotient} and holds the pipeline while busy.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             cancel_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             stall_req_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned cntWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state;
  state_t              stateNext;
  logic [cntWidth-1:0] count;
  logic [WIDTH-1:0]    rem;
  logic [WIDTH-1:0]    quo;
  logic [WIDTH-1:0]    divisor;
  logic [WIDTH-1:0]    aOrig;
  logic                aSign;
  logic                bSign;
  logic                divZero;

  logic                aNeg;
  logic                bNeg;
  logic [WIDTH-1:0]    aAbs;
  logic [WIDTH-1:0]    bAbs;
  logic [WIDTH:0]      remShift;
  logic [WIDTH-1:0]    remDiff;
  logic [WIDTH-1:0]    remNext;
  logic [WIDTH-1:0]    quoNext;
  logic [WIDTH-1:0]    hiFinal;
  logic [WIDTH-1:0]    loFinal;
  logic                lastIter;

  assign lastIter = (count == cntWidth'(WIDTH - 1));

  // Operand magnitudes; signs only matter for DIV
  always_comb begin
    aNeg = signed_i & a_i[WIDTH-1];
    bNeg = signed_i & b_i[WIDTH-1];
    aAbs = aNeg ? (~a_i + WIDTH'(1)) : a_i;
    bAbs = bNeg ? (~b_i + WIDTH'(1)) : b_i;
  end

  // One restoring step (WIDTH+1-bit compare) and sign fix-up of the resulting values
  always_comb begin
    remShift = {rem, quo[WIDTH-1]};
    // Only taken when remShift >= divisor, where the true difference fits in WIDTH bits
    remDiff  = remShift[WIDTH-1:0] - divisor;
    remNext  = remShift[WIDTH-1:0];
    quoNext  = {quo[WIDTH-2:0], 1'b0};
    if (remShift >= {1'b0, divisor}) begin
      remNext = remDiff;
      quoNext = {quo[WIDTH-2:0], 1'b1};
    end
    // Zero divisor returns the untouched dividend and an all-ones quotient
    if (divZero) begin
      hiFinal = aOrig;
      loFinal = '1;
    end else begin
      hiFinal = aSign ? (~remNext + WIDTH'(1)) : remNext;
      loFinal = (aSign ^ bSign) ? (~quoNext + WIDTH'(1)) : quoNext;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next state, stall request and ready pulse; a flush overrides everything
  always_comb begin
    stateNext   = state;
    stall_req_o = 1'b0;
    ready_o     = 1'b0;
    if (cancel_i) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE: begin
          stall_req_o = start_i;
          if (start_i) begin
`ifdef DIV_ZERO_FAST_EN
            stateNext = (b_i == '0) ? DONE : BUSY;
`else
            stateNext = BUSY;
`endif
          end
        end
        BUSY: begin
          stall_req_o = 1'b1;
          if (lastIter) stateNext = DONE;
        end
        DONE: begin
          ready_o   = 1'b1;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // Operand capture, iteration and result registration on DONE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      rem     <= '0;
      quo     <= '0;
      divisor <= '0;
      aOrig   <= '0;
      aSign   <= 1'b0;
      bSign   <= 1'b0;
      divZero <= 1'b0;
      hi_o    <= '0;
      lo_o    <= '0;
    end else if (!cancel_i) begin
      case (state)
        IDLE: begin
          if (start_i) begin
            count   <= '0;
            rem     <= '0;
            quo     <= aAbs;
            divisor <= bAbs;
            aOrig   <= a_i;
            aSign   <= aNeg;
            bSign   <= bNeg;
            divZero <= (b_i == '0);
`ifdef DIV_ZERO_FAST_EN
            if (b_i == '0) begin
              hi_o <= a_i;
              lo_o <= '1;
            end
`endif
          end
        end
        BUSY: begin
          rem   <= remNext;
          quo   <= quoNext;
          count <= count + cntWidth'(1);
          if (lastIter) begin
            hi_o <= hiFinal;
            lo_o <= loFinal;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
